// File: rtl/hex_print_fmt_pkg.sv
// Shared types and ASCII constants for the hex print formatter.
// Holds the controller state encoding and the kind of character currently selected.
package hex_print_fmt_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, DONE} state_t;

    // K_END marks that the last character of the job has been transferred.
    typedef enum logic [2:0] {K_BYTE, K_DIGIT, K_SEP, K_CR, K_LF, K_END} kind_t;

    localparam logic [7:0] CH_US    = 8'h5F;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_A_M10 = 8'h37;

endpackage

// File: rtl/hex_print_fmt_if.sv
// Print request (DCP side) and character stream (uart_tx side) bundle.
// master = request issuer and uart model, slave = the formatter.
interface hex_print_fmt_if #(parameter int DATA_W = 32) ();

    logic [DATA_W-1:0] dout_tx;
    logic              type_tx;
    logic              req_tx;
    logic              ack_tx;
    logic              busy;
    logic [7:0]        d_tx;
    logic              vld_tx;
    logic              rdy_tx;

    modport master (
        output dout_tx, type_tx, req_tx, rdy_tx,
        input  ack_tx, busy, d_tx, vld_tx
    );

    modport slave (
        input  dout_tx, type_tx, req_tx, rdy_tx,
        output ack_tx, busy, d_tx, vld_tx
    );

endinterface

// File: rtl/hex_print_fmt_nibble_to_ascii.sv
// Combinational conversion of one nibble to its uppercase ASCII hex digit.
module nibble_to_ascii
    import hex_print_fmt_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] ch
);

    assign ch = (nib < 4'd10) ? (CH_0 + {4'h0, nib}) : (CH_A_M10 + {4'h0, nib});

endmodule

// File: rtl/hex_print_fmt.sv
// Turns a latched print request into a byte or hex-digit character stream
// with vld/rdy flow control towards uart_tx and a one-cycle completion ack.
module hex_print_fmt
    import hex_print_fmt_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int SEP_GROUP = 4,
    parameter int NL_EN     = 1
) (
    input  logic           clk,
    input  logic           rst,
    hex_print_fmt_if.slave bus
);

    localparam int N     = DATA_W / 4;
    localparam int DIG_W = $clog2(N) + 1;
    localparam int GRP_W = $clog2(SEP_GROUP + 1) + 1;

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d;
    logic              req_dly_q, req_dly_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DIG_W-1:0]  digit_q, digit_d;
    logic [GRP_W-1:0]  grp_q, grp_d;
    logic [7:0]        d_q, d_d;

    logic       start;
    logic [3:0] nib;
    logic [7:0] nib_ch;
    logic [7:0] char_c;

    assign start     = bus.req_tx & ~req_dly_q;
    assign req_dly_d = bus.req_tx;

    // Most significant nibble is digit 0.
    always_comb begin
        nib = '0;
        for (int i = 0; i < N; i++) begin
            if (digit_q == DIG_W'(i)) nib = data_q[4*(N-1-i) +: 4];
        end
    end

    nibble_to_ascii u_n2a (
        .nib (nib),
        .ch  (nib_ch)
    );

    always_comb begin
        case (kind_q)
            K_BYTE:  char_c = data_q[7:0];
            K_DIGIT: char_c = nib_ch;
            K_SEP:   char_c = CH_US;
            K_CR:    char_c = CH_CR;
            K_LF:    char_c = CH_LF;
            default: char_c = '0;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d = state_q;
        kind_d  = kind_q;
        data_d  = data_q;
        digit_d = digit_q;
        grp_d   = grp_q;
        d_d     = d_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    data_d  = bus.dout_tx;
                    kind_d  = bus.type_tx ? K_DIGIT : K_BYTE;
                    digit_d = '0;
                    grp_d   = '0;
                end
            end
            LOAD: begin
                d_d     = char_c;
                state_d = SEND;
            end
            SEND: begin
                // Counters advance only on a transfer, so d_tx is frozen while rdy_tx is low.
                if (bus.rdy_tx) begin
                    state_d = GAP;
                    case (kind_q)
                        K_DIGIT: begin
                            digit_d = digit_q + 1'b1;
                            if (digit_d == DIG_W'(N)) begin
                                kind_d = (NL_EN != 0) ? K_CR : K_END;
                                grp_d  = '0;
                            end else if (SEP_GROUP != 0 && grp_q == GRP_W'(SEP_GROUP - 1)) begin
                                kind_d = K_SEP;
                                grp_d  = '0;
                            end else begin
                                grp_d = grp_q + 1'b1;
                            end
                        end
                        K_SEP:   kind_d = K_DIGIT;
                        K_CR:    kind_d = K_LF;
                        default: kind_d = K_END;
                    endcase
                end
            end
            GAP: begin
                if (kind_q == K_END) begin
                    state_d = DONE;
                end else begin
                    d_d     = char_c;
                    state_d = SEND;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; reset is synchronous and covers every flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            kind_q    <= K_BYTE;
            req_dly_q <= 1'b0;
            data_q    <= '0;
            digit_q   <= '0;
            grp_q     <= '0;
            d_q       <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            req_dly_q <= req_dly_d;
            data_q    <= data_d;
            digit_q   <= digit_d;
            grp_q     <= grp_d;
            d_q       <= d_d;
        end
    end

    assign bus.vld_tx = (state_q == SEND);
    assign bus.d_tx   = d_q;
    assign bus.ack_tx = (state_q == DONE);
    assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_hex_print_fmt.sv
// Self-checking bench: a 32-bit default formatter and a 16-bit plain one,
// checked against a string-level model of the expected character stream.
module tb_hex_print_fmt;

    typedef logic [7:0] q8_t [$];

    logic clk;
    logic rst;

    hex_print_fmt_if #(.DATA_W(32)) b32 ();
    hex_print_fmt_if #(.DATA_W(16)) b16 ();

    hex_print_fmt #(.DATA_W(32), .SEP_GROUP(4), .NL_EN(1)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32.slave)
    );

    hex_print_fmt #(.DATA_W(16), .SEP_GROUP(0), .NL_EN(0)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16.slave)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q [$];
    int         recv = 0;
    int         ack32 = 0;
    int         ack16 = 0;
    bit         hold32 = 0, hold16 = 0;
    logic [7:0] hd32 = '0, hd16 = '0;
    bit         acked;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected characters from the formatting rules: hex text of the value, '_' every
    // sep digits, then CR LF; byte mode is the low byte alone.
    function automatic q8_t model_chars(input logic [63:0] data, input bit word,
                                        input int dw, input int sep, input bit nl);
        q8_t q;
        int  n, nib;
        if (!word) begin
            q.push_back(data[7:0]);
        end else begin
            n = dw / 4;
            for (int k = 0; k < n; k++) begin
                if (sep > 0 && k > 0 && (k % sep) == 0) q.push_back(8'h5F);
                nib = int'((data >> (4 * (n - 1 - k))) & 64'hF);
                q.push_back(nib < 10 ? 8'(48 + nib) : 8'(65 + nib - 10));
            end
            if (nl) begin
                q.push_back(8'h0D);
                q.push_back(8'h0A);
            end
        end
        return q;
    endfunction

    task automatic observe(input string tag, input logic vld, input logic rdy, input logic ack,
                           input logic [7:0] d, input bit was_held, input logic [7:0] held_d,
                           output bit got_ack);
        logic [7:0] e;
        got_ack = 0;
        if (ack) begin
            got_ack = 1;
            check({tag, "_ack_with_vld"}, 64'(vld), 64'd0);
            check({tag, "_ack_before_all_chars"}, 64'(exp_q.size()), 64'd0);
        end
        if (was_held) begin
            check({tag, "_held_vld_dropped"}, 64'(vld), 64'd1);
            check({tag, "_held_char_changed"}, 64'(d), 64'(held_d));
        end
        if (vld && rdy) begin
            if (exp_q.size() == 0) begin
                check({tag, "_unexpected_char"}, 64'(d), 64'h100);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_char"}, 64'(d), 64'(e));
            end
            recv++;
        end
    endtask

    // Single compare process: all stream/ack properties are checked on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            observe("w32", b32.vld_tx, b32.rdy_tx, b32.ack_tx, b32.d_tx, hold32, hd32, acked);
            if (acked) ack32++;
            observe("w16", b16.vld_tx, b16.rdy_tx, b16.ack_tx, b16.d_tx, hold16, hd16, acked);
            if (acked) ack16++;
        end
        hold32 = !rst && b32.vld_tx && !b32.rdy_tx;
        hd32   = b32.d_tx;
        hold16 = !rst && b16.vld_tx && !b16.rdy_tx;
        hd16   = b16.d_tx;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input bit which, input logic [63:0] data, input bit word);
        q8_t q;
        q = which ? model_chars(data, word, 16, 0, 0) : model_chars(data, word, 32, 4, 1);
        foreach (q[i]) exp_q.push_back(q[i]);
        if (which) begin
            b16.dout_tx = data[15:0];
            b16.type_tx = word;
            b16.req_tx  = 1'b1;
        end else begin
            b32.dout_tx = data[31:0];
            b32.type_tx = word;
            b32.req_tx  = 1'b1;
        end
        cycle();
        b32.req_tx = 1'b0;
        b16.req_tx = 1'b0;
    endtask

    task automatic wait_ack(input bit which, input int target);
        int n = 0;
        while ((which ? ack16 : ack32) < target && n < 1000) begin
            cycle();
            n++;
        end
        check(which ? "w16_ack_count" : "w32_ack_count", 64'(which ? ack16 : ack32), 64'(target));
    endtask

    task automatic wait_recv(input int target);
        int n = 0;
        while (recv < target && n < 1000) begin
            cycle();
            n++;
        end
        check("chars_received_in_time", 64'(recv >= target), 64'd1);
    endtask

    task automatic pin_model(input string name, input q8_t got, input q8_t want);
        check({name, "_len"}, 64'(got.size()), 64'(want.size()));
        foreach (want[i]) begin
            if (i < got.size()) check({name, "_char"}, 64'(got[i]), 64'(want[i]));
        end
    endtask

    initial begin
        q8_t lit;
        int  base;

        rst = 1'b1;
        b32.req_tx = 1'b0; b32.type_tx = 1'b0; b32.dout_tx = '0; b32.rdy_tx = 1'b1;
        b16.req_tx = 1'b0; b16.type_tx = 1'b0; b16.dout_tx = '0; b16.rdy_tx = 1'b1;

        // Hand-computed streams pin the model before it is trusted.
        lit = '{8'h31};
        pin_model("model_byte", model_chars(64'h31, 0, 32, 4, 1), lit);
        lit = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h5F, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
        pin_model("model_word", model_chars(64'h1234ABCD, 1, 32, 4, 1), lit);
        lit = '{8'h42, 8'h45, 8'h45, 8'h46};
        pin_model("model_beef", model_chars(64'hBEEF, 1, 16, 0, 0), lit);

        repeat (3) cycle();
        check("rst_vld",  64'(b32.vld_tx), 64'd0);
        check("rst_busy", 64'(b32.busy),   64'd0);
        check("rst_ack",  64'(b32.ack_tx), 64'd0);
        check("rst_d",    64'(b32.d_tx),   64'd0);
        check("rst_vld16", 64'(b16.vld_tx), 64'd0);
        rst = 1'b0;
        cycle();

        // Byte mode, including start-to-vld latency.
        start_job(0, 64'h31, 0);
        check("byte_vld_in_load", 64'(b32.vld_tx), 64'd0);
        check("byte_busy",        64'(b32.busy),   64'd1);
        cycle();
        check("byte_vld_latency", 64'(b32.vld_tx), 64'd1);
        check("byte_d",           64'(b32.d_tx),   64'h31);
        wait_ack(0, 1);
        check("byte_busy_after_ack", 64'(b32.busy), 64'd0);
        check("byte_stream_done",    64'(exp_q.size()), 64'd0);

        // Word mode with separator and terminator.
        start_job(0, 64'h1234ABCD, 1);
        wait_ack(0, 2);
        check("word_stream_done", 64'(exp_q.size()), 64'd0);

        // Backpressure mid-word.
        base = recv;
        start_job(0, 64'hDEADBEEF, 1);
        wait_recv(base + 3);
        b32.rdy_tx = 1'b0;
        repeat (50) cycle();
        check("bp_vld_waiting", 64'(b32.vld_tx), 64'd1);
        b32.rdy_tx = 1'b1;
        wait_ack(0, 3);
        check("bp_stream_done", 64'(exp_q.size()), 64'd0);

        // Held request plus a re-pulse while busy gives exactly one job.
        begin
            q8_t q;
            q = model_chars(64'h0F0F0F0F, 1, 32, 4, 1);
            foreach (q[i]) exp_q.push_back(q[i]);
        end
        b32.dout_tx = 32'h0F0F0F0F;
        b32.type_tx = 1'b1;
        b32.req_tx  = 1'b1;
        repeat (4) cycle();
        b32.req_tx = 1'b0;
        cycle();
        b32.req_tx = 1'b1;
        b32.dout_tx = 32'h55555555;
        repeat (200) cycle();
        b32.req_tx = 1'b0;
        repeat (30) cycle();
        check("hold_one_ack",     64'(ack32), 64'd4);
        check("hold_stream_done", 64'(exp_q.size()), 64'd0);
        check("hold_busy_low",    64'(b32.busy), 64'd0);

        // Reset while the fifth character is presented.
        base = recv;
        start_job(0, 64'h1234ABCD, 1);
        wait_recv(base + 4);
        b32.rdy_tx = 1'b0;
        begin
            int n = 0;
            while (!b32.vld_tx && n < 20) begin
                cycle();
                n++;
            end
        end
        check("abort_fifth_presented", 64'(b32.d_tx), 64'h5F);
        rst = 1'b1;
        cycle();
        check("abort_vld_low",  64'(b32.vld_tx), 64'd0);
        check("abort_busy_low", 64'(b32.busy),   64'd0);
        rst = 1'b0;
        b32.rdy_tx = 1'b1;
        exp_q.delete();
        repeat (20) cycle();
        check("abort_no_ack", 64'(ack32), 64'd4);
        start_job(0, 64'h1234ABCD, 1);
        wait_ack(0, 5);
        check("after_abort_stream_done", 64'(exp_q.size()), 64'd0);

        // Narrow instance: no separator, no terminator.
        start_job(1, 64'hBEEF, 1);
        wait_ack(1, 1);
        check("beef_stream_done", 64'(exp_q.size()), 64'd0);
        check("beef_busy_low",    64'(b16.busy), 64'd0);
        check("w32_untouched",    64'(ack32), 64'd5);

        repeat (5) cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
